// File: rtl/handshake_protocol_monitor_if.sv
// Ready/valid bundle for N parallel channels; channel i owns bit i of valid/ready
// and data[i*DATA_W +: DATA_W].
interface handshake_protocol_monitor_if #(
  parameter int N_CH   = 3,
  parameter int DATA_W = 5
);
  logic [N_CH-1:0]        valid;
  logic [N_CH-1:0]        ready;
  logic [N_CH*DATA_W-1:0] data;

  modport master  (output valid, output data, input ready);
  modport slave   (input valid, input data, output ready);
  modport monitor (input valid, input ready, input data);
endinterface

// File: rtl/handshake_protocol_monitor.sv
// Passive per-channel ready/valid protocol checker: transfer counts, sticky
// valid-drop / data-change / stall flags and first-error capture.
module handshake_protocol_monitor #(
  parameter int N_CH      = 3,
  parameter int DATA_W    = 5,
  parameter int CNT_W     = 16,
  parameter int STALL_MAX = 64
) (
  input  logic                             CLK,
  input  logic                             RESET,
  handshake_protocol_monitor_if.monitor    bus,
  input  logic                             clear,
  output logic [N_CH*CNT_W-1:0]            xfer_count,
  output logic [N_CH-1:0]                  err_valid_drop,
  output logic [N_CH-1:0]                  err_data_change,
  output logic [N_CH-1:0]                  err_stall,
  output logic                             any_error,
  output logic                             first_err_valid,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] first_err_ch,
  output logic [1:0]                       first_err_code
);
  localparam int          CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [15:0] STALL_LAST = 16'(STALL_MAX - 1);
  localparam logic [15:0] STALL_TOP  = 16'(STALL_MAX);

  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

  state_t            state_r     [N_CH];
  logic [DATA_W-1:0] latch_r     [N_CH];
  logic [15:0]       stall_cnt_r [N_CH];
  logic [CNT_W-1:0]  cnt_r       [N_CH];

  logic [N_CH-1:0] xfer_s, ev_vd_s, ev_dc_s, ev_st_s;
  logic            fe_hit_s;
  logic [CH_W-1:0] fe_ch_s;
  logic [1:0]      fe_code_s;
  logic [1:0]      code_s [N_CH];

  // Per-channel violation events for this cycle, and lowest-channel / lowest-code pick
  always_comb begin
    fe_ch_s   = {CH_W{1'b0}};
    fe_code_s = 2'd0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      xfer_s[i]  = bus.valid[i] & bus.ready[i];
      ev_vd_s[i] = (state_r[i] == ST_PEND) & ~bus.valid[i];
      ev_dc_s[i] = (state_r[i] == ST_PEND) & bus.valid[i] &
                   (bus.data[i*DATA_W +: DATA_W] != latch_r[i]);
      ev_st_s[i] = (state_r[i] == ST_PEND) & bus.valid[i] & ~bus.ready[i] &
                   (stall_cnt_r[i] == STALL_LAST);
      code_s[i]  = ev_vd_s[i] ? 2'd1 : (ev_dc_s[i] ? 2'd2 : (ev_st_s[i] ? 2'd3 : 2'd0));
      fe_ch_s    = (code_s[i] != 2'd0) ? CH_W'(i) : fe_ch_s;
      fe_code_s  = (code_s[i] != 2'd0) ? code_s[i] : fe_code_s;
    end
    fe_hit_s = |(ev_vd_s | ev_dc_s | ev_st_s);
  end

  // Channel FSM, payload latch and stall counter; clear deliberately leaves these running
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_CH; i++) begin
      if (RESET) begin
        state_r[i]     <= ST_IDLE;
        latch_r[i]     <= {DATA_W{1'b0}};
        stall_cnt_r[i] <= 16'd0;
      end else begin
        case (state_r[i])
          ST_IDLE: begin
            if (bus.valid[i] && !bus.ready[i]) begin
              state_r[i] <= ST_PEND;
              latch_r[i] <= bus.data[i*DATA_W +: DATA_W];
            end
            stall_cnt_r[i] <= 16'd0;
          end
          ST_PEND: begin
            if (!bus.valid[i] || bus.ready[i]) begin
              state_r[i]     <= ST_IDLE;
              stall_cnt_r[i] <= 16'd0;
            end else if (stall_cnt_r[i] != STALL_TOP) begin
              stall_cnt_r[i] <= stall_cnt_r[i] + 16'd1;
            end
          end
          default: begin
            state_r[i]     <= ST_IDLE;
            stall_cnt_r[i] <= 16'd0;
          end
        endcase
      end
    end
  end

  // Saturating transfer counters, sticky flags and first-error capture
  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      for (int i = 0; i < N_CH; i++) cnt_r[i] <= {CNT_W{1'b0}};
      err_valid_drop  <= {N_CH{1'b0}};
      err_data_change <= {N_CH{1'b0}};
      err_stall       <= {N_CH{1'b0}};
      any_error       <= 1'b0;
      first_err_valid <= 1'b0;
      first_err_ch    <= {CH_W{1'b0}};
      first_err_code  <= 2'd0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (xfer_s[i] && (cnt_r[i] != {CNT_W{1'b1}})) cnt_r[i] <= cnt_r[i] + CNT_W'(1);
      end
      err_valid_drop  <= err_valid_drop  | ev_vd_s;
      err_data_change <= err_data_change | ev_dc_s;
      err_stall       <= err_stall       | ev_st_s;
      any_error       <= any_error | fe_hit_s;
      if (!first_err_valid && fe_hit_s) begin
        first_err_valid <= 1'b1;
        first_err_ch    <= fe_ch_s;
        first_err_code  <= fe_code_s;
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    assign xfer_count[g*CNT_W +: CNT_W] = cnt_r[g];
  end
endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// Randomized + directed bench for handshake_protocol_monitor against a run-length
// based reference model of the ready/valid rules.
module tb_handshake_protocol_monitor;
  localparam int N_CH = 3, DATA_W = 5, CNT_W = 4, STALL_MAX = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic clear = 1'b0;
  logic [N_CH*CNT_W-1:0] xfer_count;
  logic [N_CH-1:0] err_valid_drop, err_data_change, err_stall;
  logic any_error, first_err_valid;
  logic [1:0] first_err_ch, first_err_code;

  handshake_protocol_monitor_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

  handshake_protocol_monitor #(.N_CH(N_CH), .DATA_W(DATA_W), .CNT_W(CNT_W), .STALL_MAX(STALL_MAX)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus), .clear(clear),
    .xfer_count(xfer_count), .err_valid_drop(err_valid_drop),
    .err_data_change(err_data_change), .err_stall(err_stall),
    .any_error(any_error), .first_err_valid(first_err_valid),
    .first_err_ch(first_err_ch), .first_err_code(first_err_code)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a channel is pending iff the previous cycle had valid&!ready.
  int       runlen [N_CH];
  int       anchor [N_CH];
  int       m_cnt  [N_CH];
  bit       m_vd [N_CH], m_dc [N_CH], m_st [N_CH];
  bit       m_fev;
  int       m_fch, m_fcode;

  always @(posedge CLK) begin
    bit v, r, evd, edc, est, taken;
    int d;
    if (RESET) begin
      for (int i = 0; i < N_CH; i++) begin
        runlen[i] = 0; anchor[i] = 0; m_cnt[i] = 0;
        m_vd[i] = 0; m_dc[i] = 0; m_st[i] = 0;
      end
      m_fev = 0; m_fch = 0; m_fcode = 0;
      check_en = 1'b1;
    end else begin
      taken = m_fev;
      for (int i = 0; i < N_CH; i++) begin
        v = bus.valid[i]; r = bus.ready[i];
        d = int'(bus.data[i*DATA_W +: DATA_W]);
        evd = (runlen[i] > 0) && !v;
        edc = (runlen[i] > 0) && v && (d != anchor[i]);
        est = v && !r && (runlen[i] == STALL_MAX);
        if (clear) begin
          m_cnt[i] = 0; m_vd[i] = 0; m_dc[i] = 0; m_st[i] = 0;
        end else begin
          if (v && r && m_cnt[i] < 15) m_cnt[i] = m_cnt[i] + 1;
          m_vd[i] |= evd; m_dc[i] |= edc; m_st[i] |= est;
          if (!taken && (evd || edc || est)) begin
            taken = 1; m_fev = 1; m_fch = i;
            m_fcode = evd ? 1 : (edc ? 2 : 3);
          end
        end
        if (v && !r) begin
          if (runlen[i] == 0) anchor[i] = d;
          if (runlen[i] < 1000) runlen[i] = runlen[i] + 1;
        end else begin
          runlen[i] = 0;
        end
      end
      if (clear) begin
        m_fev = 0; m_fch = 0; m_fcode = 0;
      end
    end
  end

  // Single compare process against the model, every cycle after first reset edge
  always @(negedge CLK) begin
    if (check_en) begin
      bit any;
      any = 0;
      for (int i = 0; i < N_CH; i++) begin
        chk($sformatf("xfer_count[%0d]", i), int'(xfer_count[i*CNT_W +: CNT_W]), m_cnt[i]);
        chk($sformatf("err_valid_drop[%0d]", i), int'(err_valid_drop[i]), int'(m_vd[i]));
        chk($sformatf("err_data_change[%0d]", i), int'(err_data_change[i]), int'(m_dc[i]));
        chk($sformatf("err_stall[%0d]", i), int'(err_stall[i]), int'(m_st[i]));
        any |= m_vd[i] | m_dc[i] | m_st[i];
      end
      chk("any_error", int'(any_error), int'(any));
      chk("first_err_valid", int'(first_err_valid), int'(m_fev));
      chk("first_err_ch", int'(first_err_ch), m_fch);
      chk("first_err_code", int'(first_err_code), m_fcode);
    end
  end

  // One cycle of stimulus; returns at the next negedge with that edge's results visible
  task automatic step(input logic [2:0] v, input logic [2:0] r, input logic [14:0] d, input logic clr);
    bus.valid = v; bus.ready = r; bus.data = d; clear = clr;
    @(negedge CLK);
  endtask

  initial begin
    logic [2:0] rv, rr;
    logic [14:0] rd;
    bus.valid = 3'b000; bus.ready = 3'b000; bus.data = 15'd0;
    RESET = 1'b1;
    @(negedge CLK); @(negedge CLK);
    chk("reset any_error", int'(any_error), 0);
    chk("reset xfer_count", int'(xfer_count), 0);
    RESET = 1'b0;

    // 1: four transfers on ch1
    repeat (4) step(3'b010, 3'b010, 15'd0, 1'b0);
    chk("t1 xfer ch1", int'(xfer_count[7:4]), 4);
    chk("t1 xfer ch0", int'(xfer_count[3:0]), 0);
    chk("t1 any_error", int'(any_error), 0);
    step(3'b000, 3'b000, 15'd0, 1'b0);

    // 2: valid drop on ch0
    step(3'b001, 3'b000, {5'h00, 5'h00, 5'h0A}, 1'b0);
    chk("t2 no early drop", int'(err_valid_drop[0]), 0);
    step(3'b000, 3'b000, 15'd0, 1'b0);
    chk("t2 vd ch0", int'(err_valid_drop[0]), 1);
    chk("t2 first ch", int'(first_err_ch), 0);
    chk("t2 first code", int'(first_err_code), 1);

    // 3: ch2 data change with ch1 valid drop in the same cycle
    step(3'b000, 3'b000, 15'd0, 1'b1);
    step(3'b110, 3'b000, {5'h03, 5'h07, 5'h00}, 1'b0);
    step(3'b100, 3'b000, {5'h04, 5'h07, 5'h00}, 1'b0);
    chk("t3 dc ch2", int'(err_data_change[2]), 1);
    chk("t3 vd ch1", int'(err_valid_drop[1]), 1);
    chk("t3 first ch", int'(first_err_ch), 1);
    chk("t3 first code", int'(first_err_code), 1);
    step(3'b000, 3'b000, 15'd0, 1'b0);

    // 4: stall on ch1 with STALL_MAX=4
    step(3'b000, 3'b000, 15'd0, 1'b1);
    repeat (4) step(3'b010, 3'b000, {5'h00, 5'h09, 5'h00}, 1'b0);
    chk("t4 stall not yet", int'(err_stall[1]), 0);
    step(3'b010, 3'b000, {5'h00, 5'h09, 5'h00}, 1'b0);
    chk("t4 stall set", int'(err_stall[1]), 1);
    chk("t4 stall code", int'(first_err_code), 3);
    repeat (5) step(3'b010, 3'b000, {5'h00, 5'h09, 5'h00}, 1'b0);
    chk("t4 stall held", int'(err_stall[1]), 1);
    step(3'b010, 3'b010, {5'h00, 5'h09, 5'h00}, 1'b0);
    chk("t4 xfer ch1", int'(xfer_count[7:4]), 1);
    step(3'b000, 3'b000, 15'd0, 1'b0);

    // 5: saturation, then clear colliding with a transfer
    repeat (20) step(3'b001, 3'b001, 15'd0, 1'b0);
    chk("t5 saturated", int'(xfer_count[3:0]), 15);
    step(3'b001, 3'b001, 15'd0, 1'b1);
    chk("t5 clear wins", int'(xfer_count[3:0]), 0);
    step(3'b000, 3'b000, 15'd0, 1'b0);

    // 6: reset while ch0 pending, then valid low
    step(3'b001, 3'b000, {5'h00, 5'h00, 5'h11}, 1'b0);
    step(3'b001, 3'b000, {5'h00, 5'h00, 5'h11}, 1'b0);
    RESET = 1'b1;
    step(3'b001, 3'b000, {5'h00, 5'h00, 5'h11}, 1'b0);
    RESET = 1'b0;
    step(3'b000, 3'b000, 15'd0, 1'b0);
    chk("t6 any_error", int'(any_error), 0);
    chk("t6 first valid", int'(first_err_valid), 0);
    chk("t6 xfer", int'(xfer_count), 0);

    // Randomized phase with sticky per-channel patterns so long stalls occur
    rv = 3'b000; rr = 3'b000; rd = 15'd0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          rv[i] = 1'($urandom_range(0, 1));
          rr[i] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 7) == 0) rd[i*5 +: 5] = 5'($urandom_range(0, 3));
      end
      RESET = ($urandom_range(0, 499) == 0);
      step(rv, rr, rd, ($urandom_range(0, 63) == 0));
    end
    RESET = 1'b0;
    step(3'b000, 3'b000, 15'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
